// File: rtl/traffic_pkg.sv
// Shared phase encoding, light codes and phase helpers for the traffic phase controller.
package traffic_pkg;

    localparam int unsigned TIMER_W_DEF = 8;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        ST_MAIN_GREEN  = 3'd0,
        ST_MAIN_YELLOW = 3'd1,
        ST_ALL_RED_A   = 3'd2,
        ST_SIDE_GREEN  = 3'd3,
        ST_SIDE_YELLOW = 3'd4,
        ST_ALL_RED_B   = 3'd5
    } phase_e;

    typedef struct packed {
        logic [2:0] main_l;
        logic [2:0] side_l;
    } lights_t;

    // Fixed ring order of the signal cycle.
    function automatic phase_e next_phase(input phase_e s);
        case (s)
            ST_MAIN_GREEN:  return ST_MAIN_YELLOW;
            ST_MAIN_YELLOW: return ST_ALL_RED_A;
            ST_ALL_RED_A:   return ST_SIDE_GREEN;
            ST_SIDE_GREEN:  return ST_SIDE_YELLOW;
            ST_SIDE_YELLOW: return ST_ALL_RED_B;
            default:        return ST_MAIN_GREEN;
        endcase
    endfunction

    function automatic lights_t decode_lights(input phase_e s);
        case (s)
            ST_MAIN_GREEN:  return '{main_l: LIGHT_GREEN,  side_l: LIGHT_RED};
            ST_MAIN_YELLOW: return '{main_l: LIGHT_YELLOW, side_l: LIGHT_RED};
            ST_SIDE_GREEN:  return '{main_l: LIGHT_RED,    side_l: LIGHT_GREEN};
            ST_SIDE_YELLOW: return '{main_l: LIGHT_RED,    side_l: LIGHT_YELLOW};
            default:        return '{main_l: LIGHT_RED,    side_l: LIGHT_RED};
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-enabled phase down-counter: counts to 1, then reloads on request or holds at 1.
module phase_timer #(
    parameter int unsigned         TIMER_W   = 8,
    parameter logic [TIMER_W-1:0]  RESET_VAL = TIMER_W'(10)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_en,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic [TIMER_W-1:0] count,
    output logic [TIMER_W-1:0] count_next_c,
    output logic               is_last_c
);

    assign is_last_c = (count == TIMER_W'(1));

    always_comb begin
        count_next_c = count;
        if (tick_en) begin
            if (!is_last_c) begin
                count_next_c = count - TIMER_W'(1);
            end else if (load) begin
                count_next_c = load_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= RESET_VAL;
        end else begin
            count <= count_next_c;
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// Main/side road signal sequencer with pedestrian walk, advanced only on divider ticks.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int unsigned TIMER_W      = TIMER_W_DEF,
    parameter int unsigned T_MAIN_GREEN = 10,
    parameter int unsigned T_YELLOW     = 3,
    parameter int unsigned T_ALL_RED    = 1,
    parameter int unsigned T_SIDE_GREEN = 6,
    parameter int unsigned T_PED_CLEAR  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_en,
    input  logic               side_car,
    input  logic               ped_req,
    output logic [2:0]         main_light,
    output logic [2:0]         side_light,
    output logic               ped_walk,
    output logic               ped_wait,
    output logic [TIMER_W-1:0] phase_remaining
);

    phase_e             state;
    phase_e             state_next;
    logic               walk_active;
    logic               walk_next;
    logic               ped_pending;
    logic               pend_next;
    logic               exit_c;
    logic               is_last;
    logic               enter_side_c;
    logic               leave_side_c;
    logic               serve_c;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_next;
    logic [TIMER_W-1:0] load_val;
    lights_t            lights_next;

    function automatic logic [TIMER_W-1:0] phase_len(input phase_e s);
        case (s)
            ST_MAIN_GREEN:                 return TIMER_W'(T_MAIN_GREEN);
            ST_MAIN_YELLOW, ST_SIDE_YELLOW: return TIMER_W'(T_YELLOW);
            ST_SIDE_GREEN:                 return TIMER_W'(T_SIDE_GREEN);
            default:                       return TIMER_W'(T_ALL_RED);
        endcase
    endfunction

    phase_timer #(
        .TIMER_W   (TIMER_W),
        .RESET_VAL (TIMER_W'(T_MAIN_GREEN))
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .tick_en      (tick_en),
        .load         (exit_c),
        .load_val     (load_val),
        .count        (timer_q),
        .count_next_c (timer_next),
        .is_last_c    (is_last)
    );

    // Main green only yields once there is someone waiting for the side phase.
    assign exit_c = tick_en & is_last &
                    ((state != ST_MAIN_GREEN) | side_car | ped_pending);
    assign load_val     = phase_len(next_phase(state));
    assign state_next   = exit_c ? next_phase(state) : state;
    assign enter_side_c = exit_c & (state == ST_ALL_RED_A);
    assign leave_side_c = exit_c & (state == ST_SIDE_GREEN);
    assign serve_c      = enter_side_c & (ped_pending | ped_req);
    assign lights_next  = decode_lights(state_next);

    // A request arriving on the side-green entry edge is served, not re-latched.
    always_comb begin
        walk_next = walk_active;
        pend_next = ped_pending;
        if (serve_c) begin
            walk_next = 1'b1;
            pend_next = 1'b0;
        end else begin
            if (leave_side_c) begin
                walk_next = 1'b0;
            end
            if (ped_req && !((state == ST_SIDE_GREEN) && walk_active)) begin
                pend_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_MAIN_GREEN;
            walk_active <= 1'b0;
            ped_pending <= 1'b0;
            main_light  <= LIGHT_GREEN;
            side_light  <= LIGHT_RED;
            ped_walk    <= 1'b0;
        end else begin
            state       <= state_next;
            walk_active <= walk_next;
            ped_pending <= pend_next;
            main_light  <= lights_next.main_l;
            side_light  <= lights_next.side_l;
            ped_walk    <= walk_next & (state_next == ST_SIDE_GREEN) &
                           (timer_next > TIMER_W'(T_PED_CLEAR));
        end
    end

    assign ped_wait        = ped_pending;
    assign phase_remaining = timer_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: vector table, directed scenarios, random run vs. phase model.
module tb_traffic_phase_controller;

    logic       clk = 1'b0;
    logic       rst, tick_en, side_car, ped_req;
    logic [2:0] main_light, side_light;
    logic       ped_walk, ped_wait;
    logic [7:0] phase_remaining;

    always #5 clk = ~clk;

    traffic_phase_controller dut (
        .clk             (clk),
        .rst             (rst),
        .tick_en         (tick_en),
        .side_car        (side_car),
        .ped_req         (ped_req),
        .main_light      (main_light),
        .side_light      (side_light),
        .ped_walk        (ped_walk),
        .ped_wait        (ped_wait),
        .phase_remaining (phase_remaining)
    );

    int checks   = 0;
    int failures = 0;
    int divc     = 0;

    // Reference model: phase index into the ring, ticks remaining, pedestrian flags.
    int dur [6] = '{10, 3, 1, 6, 3, 1};
    int m_ph, m_rem;
    bit m_pend, m_walk;

    logic [2:0] obs_main [0:63];
    logic [2:0] obs_side [0:63];
    logic       obs_walk [0:63];
    logic       obs_wait [0:63];
    int         obs_rem  [0:63];

    typedef struct {
        logic       r, t, c, q;
        logic [2:0] em, es;
        logic       ew, ewt;
        int         erem;
    } vec_t;
    vec_t tbl [14];

    function automatic logic [2:0] m_main(input int ph);
        case (ph)
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] m_side(input int ph);
        case (ph)
            3:       return 3'b001;
            4:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit t, input bit c, input bit q);
        bit ex, enter, leave, was_walk;
        int old;
        if (!r) begin
            m_ph = 0; m_rem = dur[0]; m_pend = 0; m_walk = 0;
            return;
        end
        old      = m_ph;
        was_walk = m_walk;
        ex       = t && (m_rem == 1) && (m_ph != 0 || c || m_pend);
        if (t) begin
            if (m_rem > 1) m_rem--;
            else if (ex) begin
                m_ph  = (m_ph + 1) % 6;
                m_rem = dur[m_ph];
            end
        end
        enter = ex && (old == 2);
        leave = ex && (old == 3);
        if (enter && (m_pend || q)) begin
            m_walk = 1; m_pend = 0;
        end else begin
            if (leave) m_walk = 0;
            if (q && !(old == 3 && was_walk)) m_pend = 1;
        end
    endtask

    // One clock: drive, advance the model at the edge, compare just after it.
    task automatic cyc(input logic r, input logic t, input logic c, input logic q);
        rst = r; tick_en = t; side_car = c; ped_req = q;
        @(posedge clk);
        model_step(r, t, c, q);
        #1;
        chk("main_light", 32'(main_light), 32'(m_main(m_ph)));
        chk("side_light", 32'(side_light), 32'(m_side(m_ph)));
        chk("ped_walk", 32'(ped_walk), 32'(m_walk && m_ph == 3 && m_rem > 2));
        chk("ped_wait", 32'(ped_wait), 32'(m_pend));
        chk("phase_remaining", 32'(phase_remaining), 32'(m_rem));
        chk("safety", 32'($onehot(main_light) && $onehot(side_light) &&
                          !(main_light[0] && side_light[0])), 32'd1);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        divc = 0;
    endtask

    // Divider-paced run for n ticks; ped_req pulses for one clk at (tick index, divider slot).
    task automatic run_ticks(input int n, input logic c,
                             input int pt0, input int pp0, input int pt1, input int pp1);
        int   tk = 0;
        logic t, q;
        while (tk < n) begin
            t = (divc == 9);
            q = ((tk == pt0 - 1) && (divc == pp0)) || ((tk == pt1 - 1) && (divc == pp1));
            cyc(1'b1, t, c, q);
            divc = (divc + 1) % 10;
            if (t) begin
                tk++;
                obs_main[tk] = main_light; obs_side[tk] = side_light;
                obs_walk[tk] = ped_walk;   obs_wait[tk] = ped_wait;
                obs_rem[tk]  = int'(phase_remaining);
            end
        end
    endtask

    initial begin
        int         tt [6] = '{10, 13, 14, 20, 23, 24};
        logic [5:0] tc [6] = '{6'b010100, 6'b100100, 6'b100001, 6'b100010, 6'b100100, 6'b001100};
        int         n_walk, n_clear;
        logic       car;

        // Vector table: one tick per clk, main-green hold, pedestrian-driven exit, reset abort.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 3'b100, 1'b0, 1'b0, 10};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 3'b100, 1'b0, 1'b0, 9};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 3'b100, 1'b0, 1'b1, 9};
        for (int i = 3; i <= 10; i++)
            tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 3'b100, 1'b0, 1'b1, 11 - i};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 3'b100, 1'b0, 1'b1, 3};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 3'b100, 1'b0, 1'b1, 3};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 3'b100, 1'b0, 1'b0, 10};

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].r, tbl[i].t, tbl[i].c, tbl[i].q);
            chk($sformatf("vec%0d_main", i), 32'(main_light), 32'(tbl[i].em));
            chk($sformatf("vec%0d_side", i), 32'(side_light), 32'(tbl[i].es));
            chk($sformatf("vec%0d_walk", i), 32'(ped_walk), 32'(tbl[i].ew));
            chk($sformatf("vec%0d_wait", i), 32'(ped_wait), 32'(tbl[i].ewt));
            chk($sformatf("vec%0d_rem", i), 32'(phase_remaining), 32'(tbl[i].erem));
        end

        // No demand: main green extends with the timer parked at 1.
        do_reset();
        run_ticks(30, 1'b0, -5, 0, -5, 0);
        for (int k = 9; k <= 30; k++) chk($sformatf("idle_rem_t%0d", k), 32'(obs_rem[k]), 32'd1);
        chk("idle_main", 32'(obs_main[30]), 32'b001);

        // Side car from reset: full cycle with per-phase tick counts.
        do_reset();
        run_ticks(24, 1'b1, -5, 0, -5, 0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("cycle_enter%0d", i), 32'({obs_main[tt[i]], obs_side[tt[i]]}), 32'(tc[i]));
            chk($sformatf("cycle_before%0d", i),
                32'({obs_main[tt[i] - 1], obs_side[tt[i] - 1]} != tc[i]), 32'd1);
        end

        // Pedestrian pulse at tick 4: waits, then 4 walk ticks and 2 clearance ticks.
        do_reset();
        run_ticks(20, 1'b0, 4, 9, -5, 0);
        n_walk = 0; n_clear = 0;
        for (int k = 1; k <= 20; k++)
            if (obs_side[k] == 3'b001) begin
                if (obs_walk[k]) n_walk++; else n_clear++;
            end
        chk("ped_wait_t3", 32'(obs_wait[3]), 32'd0);
        chk("ped_wait_t4", 32'(obs_wait[4]), 32'd1);
        chk("ped_wait_t13", 32'(obs_wait[13]), 32'd1);
        chk("ped_wait_t14", 32'(obs_wait[14]), 32'd0);
        chk("walk_ticks", 32'(n_walk), 32'd4);
        chk("clear_ticks", 32'(n_clear), 32'd2);

        // Request on the side-green entry edge is served; one in side yellow latches.
        do_reset();
        run_ticks(24, 1'b1, 14, 9, 21, 2);
        chk("entry_walk", 32'(obs_walk[14]), 32'd1);
        chk("entry_wait", 32'(obs_wait[14]), 32'd0);
        chk("sy_wait_before", 32'(obs_wait[20]), 32'd0);
        chk("sy_wait_after", 32'(obs_wait[21]), 32'd1);
        chk("sy_wait_held", 32'(obs_wait[24]), 32'd1);

        // Reset in side green with tick high aborts straight to main green.
        do_reset();
        run_ticks(15, 1'b1, 14, 9, -5, 0);
        chk("pre_reset_walk", 32'(ped_walk), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        divc = 0;
        chk("abort_main", 32'(main_light), 32'b001);
        chk("abort_side", 32'(side_light), 32'b100);
        chk("abort_walk", 32'(ped_walk), 32'd0);
        chk("abort_rem", 32'(phase_remaining), 32'd10);

        // Tick stuck low for 100 clk: everything frozen.
        run_ticks(5, 1'b0, -5, 0, -5, 0);
        for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 1'($urandom % 2), 1'b0);
        chk("stall_rem", 32'(phase_remaining), 32'd5);
        chk("stall_main", 32'(main_light), 32'b001);

        // Random traffic against the model.
        do_reset();
        car = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 16 == 0) car = ~car;
            cyc(1'(($urandom % 300) != 0), 1'(($urandom % 3) == 0), car,
                1'(($urandom % 25) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
